// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings and sizes for the multi-cycle instruction sequencer.
// State values are visible on the debug state port and must stay fixed.
package multicycle_sequencer_pkg;

  localparam int DSIZE           = 16;
  localparam int WAIT_W          = 4;
  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  // States that wait on a memory handshake and are guarded by the timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_wait_timer.sv
// Clear/increment wait counter shared by the FETCH and MEM handshakes.
// expired_o flags the wait cycle on which the count reaches LIMIT.
module wait_timer
  import multicycle_sequencer_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [WAIT_W:0] LIMIT_C = LIMIT[WAIT_W:0];

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = inc_i && (({1'b0, cnt_q} + 1'b1) >= LIMIT_C);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps instructions through FETCH..WB and
// drives PC/IR/regfile/data-memory strobes around handshaked memories.
//
// state  | meaning
// IDLE   | stopped at an instruction boundary, waiting for run
// FETCH  | instruction request outstanding until imem_ack
// DECODE | one cycle for the decoder outputs to settle
// EXEC   | class dispatch; branches retire here
// MEM    | data request outstanding until dmem_ack; stores retire here
// WB     | register write-back and retire
// FAULT  | memory timeout, held until reset
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             dec_wen,
  input  logic             dec_branch,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             zero,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_write,
  output logic             pc_src,
  output logic             rf_wen,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [DSIZE-1:0] retired
);

  state_e           state_q;
  state_e           state_d;
  logic [DSIZE-1:0] retired_q;

  logic   ack_sel;
  logic   wait_inc;
  logic   wait_clear;
  logic   wait_expired;
  logic   is_mem_op;
  state_e boundary_st;

  wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .clear_i   (wait_clear),
    .inc_i     (wait_inc),
    .expired_o (wait_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (pc_write) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    is_mem_op   = dec_mem_write || dec_mem_read;
    boundary_st = run ? ST_FETCH : ST_IDLE;
    ack_sel     = (state_q == ST_FETCH) ? imem_ack : dmem_ack;
    // Any cycle that is not an unacknowledged wait resets the count, so
    // both FETCH and MEM are always entered with a cleared timer.
    wait_inc    = is_wait_state(state_q) && !ack_sel;
    wait_clear  = !wait_inc;

    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack)          state_d = ST_DECODE;
        else if (wait_expired) state_d = ST_FAULT;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (is_mem_op)       state_d = ST_MEM;
        else if (dec_branch) state_d = boundary_st;
        else                 state_d = ST_WB;
      end
      ST_MEM: begin
        if (dmem_ack)          state_d = dec_mem_write ? boundary_st : ST_WB;
        else if (wait_expired) state_d = ST_FAULT;
      end
      ST_WB:    state_d = boundary_st;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state_q == ST_FETCH);
    dmem_req = (state_q == ST_MEM);
    dmem_we  = (state_q == ST_MEM) && dec_mem_write;
    busy     = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    fault    = (state_q == ST_FAULT);
    state    = state_q;
    retired  = retired_q;

    ir_load  = (state_q == ST_FETCH) && imem_ack;
    rf_wen   = (state_q == ST_WB) && dec_wen;
    pc_write = 1'b0;
    pc_src   = 1'b0;

    unique case (state_q)
      ST_EXEC: begin
        if (!(dec_mem_write || dec_mem_read) && dec_branch) begin
          pc_write = 1'b1;
          pc_src   = zero;
        end
      end
      ST_MEM: begin
        pc_write = dmem_ack && dec_mem_write;
      end
      ST_WB:   pc_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer. Each instruction is expanded
// into its expected per-cycle trace from the instruction-class rules.
module tb_multicycle_sequencer;

  localparam int TO = 15;
  localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_BR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0, run = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic        dec_wen = 1'b0, dec_branch = 1'b0;
  logic        dec_mem_read = 1'b0, dec_mem_write = 1'b0, zero = 1'b0;
  logic        imem_req, ir_load, pc_write, pc_src, rf_wen;
  logic        dmem_req, dmem_we, busy, fault;
  logic [2:0]  state;
  logic [15:0] retired;

  logic [15:0] exp_ret = '0;
  logic        p_wen, p_br, p_rd, p_wr;
  int          n_checks = 0;
  int          n_errors = 0;

  multicycle_sequencer #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .imem_ack      (imem_ack),
    .dmem_ack      (dmem_ack),
    .dec_wen       (dec_wen),
    .dec_branch    (dec_branch),
    .dec_mem_read  (dec_mem_read),
    .dec_mem_write (dec_mem_write),
    .zero          (zero),
    .imem_req      (imem_req),
    .ir_load       (ir_load),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .rf_wen        (rf_wen),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .busy          (busy),
    .fault         (fault),
    .state         (state),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [11:0] outs();
    return {state, imem_req, ir_load, pc_write, pc_src, rf_wen, dmem_req, dmem_we, busy, fault};
  endfunction

  function automatic logic rmid(input int mode);
    return (mode == 2) ? rb() : 1'(mode);
  endfunction

  // One clock: drive inputs after the falling edge, compare just after.
  task automatic cyc(input logic r, rn, ia, da, zv, input logic [2:0] st,
                     input logic ireq, irl, pcw, pcs, rfw, dreq, dwe, input string tag);
    logic [11:0] exp_v;
    @(negedge clk);
    rst = r; run = rn; imem_ack = ia; dmem_ack = da; zero = zv;
    dec_wen = p_wen; dec_branch = p_br; dec_mem_read = p_rd; dec_mem_write = p_wr;
    #1;
    exp_v = {st, ireq, irl, pcw, pcs, rfw, dreq, dwe, (st >= 3'd1 && st <= 3'd5), (st == 3'd6)};
    check_eq({tag, "/outs"}, 32'(outs()), 32'(exp_v));
    check_eq({tag, "/retired"}, 32'(retired), 32'(exp_ret));
    if (pcw) exp_ret = exp_ret + 16'd1;
  endtask

  task automatic boundary(input logic run_end);
    if (!run_end) begin
      repeat ($urandom_range(0, 2)) cyc(0, 0, rb(), rb(), rb(), 3'd0, 0, 0, 0, 0, 0, 0, 0, "idle");
      cyc(0, 1, rb(), rb(), rb(), 3'd0, 0, 0, 0, 0, 0, 0, 0, "idle_go");
    end
  endtask

  task automatic do_reset(input bit go);
    @(negedge clk);
    rst = 1'b1; run = rb(); imem_ack = rb(); dmem_ack = rb(); zero = rb();
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    #1;
    exp_ret = '0;
    check_eq("reset/outs", 32'(outs()), 32'd0);
    check_eq("reset/retired", 32'(retired), 32'd0);
    if (go) cyc(0, 1, rb(), rb(), rb(), 3'd0, 0, 0, 0, 0, 0, 0, 0, "idle_go");
  endtask

  task automatic fault_hold(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, rb(), (i < 2) ? 1'b1 : rb(), (i < 2) ? 1'b1 : rb(), rb(), 3'd6,
          0, 0, 0, 0, 0, 0, 0, "fault_hold");
  endtask

  // fd/md: wait cycles before the ack; TO or more means no ack at all.
  task automatic do_instr(input int cls, input logic wen, zv, input int fd, md,
                          input int run_mid, input logic run_end, input bit rst_mem,
                          output bit faulted);
    logic st_we;
    faulted = 0;
    p_wen = wen;
    p_br  = (cls == C_BR) ? 1'b1 : (cls == C_ALU) ? 1'b0 : rb();
    p_rd  = (cls == C_LOAD) ? 1'b1 : (cls == C_STORE) ? rb() : 1'b0;
    p_wr  = (cls == C_STORE);
    st_we = (cls == C_STORE);

    for (int i = 0; i < fd && i < TO; i++)
      cyc(0, rmid(run_mid), 0, rb(), rb(), 3'd1, 1, 0, 0, 0, 0, 0, 0, "fetch_wait");
    if (fd >= TO) begin faulted = 1; return; end
    cyc(0, rmid(run_mid), 1, rb(), rb(), 3'd1, 1, 1, 0, 0, 0, 0, 0, "fetch_ack");
    cyc(0, rmid(run_mid), rb(), rb(), rb(), 3'd2, 0, 0, 0, 0, 0, 0, 0, "decode");

    if (cls == C_BR) begin
      cyc(0, run_end, rb(), rb(), zv, 3'd3, 0, 0, 1, zv, 0, 0, 0, "exec_branch");
      boundary(run_end);
      return;
    end
    cyc(0, rmid(run_mid), rb(), rb(), rb(), 3'd3, 0, 0, 0, 0, 0, 0, 0, "exec");
    if (cls == C_ALU) begin
      cyc(0, run_end, rb(), rb(), rb(), 3'd5, 0, 0, 1, 0, wen, 0, 0, "wb_alu");
      boundary(run_end);
      return;
    end

    for (int i = 0; i < md && i < TO; i++) begin
      cyc(rst_mem && i == 0, rmid(run_mid), rb(), 0, rb(), 3'd4, 0, 0, 0, 0, 0, 1, st_we, "mem_wait");
      if (rst_mem) begin
        exp_ret = '0;
        cyc(0, 0, rb(), rb(), rb(), 3'd0, 0, 0, 0, 0, 0, 0, 0, "post_rst_idle");
        boundary(1'b0);
        return;
      end
    end
    if (md >= TO) begin faulted = 1; return; end
    if (cls == C_STORE) begin
      cyc(0, run_end, rb(), 1, rb(), 3'd4, 0, 0, 1, 0, 0, 1, 1, "mem_store");
      boundary(run_end);
      return;
    end
    cyc(0, rmid(run_mid), rb(), 1, rb(), 3'd4, 0, 0, 0, 0, 0, 1, 0, "mem_load");
    cyc(0, run_end, rb(), rb(), rb(), 3'd5, 0, 0, 1, 0, wen, 0, 0, "wb_load");
    boundary(run_end);
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 0;
    if (r < 9) return $urandom_range(1, 3);
    return TO - 1;
  endfunction

  initial begin
    bit f;
    p_wen = 0; p_br = 0; p_rd = 0; p_wr = 0;

    do_reset(1);
    do_instr(C_ALU,   1, 0, 0, 0, 1, 1, 0, f);
    do_instr(C_LOAD,  1, 0, 0, 2, 1, 1, 0, f);
    do_instr(C_BR,    1, 1, 0, 0, 1, 1, 0, f);
    do_instr(C_BR,    1, 0, 0, 0, 1, 1, 0, f);
    do_instr(C_STORE, 1, 0, 1, 2, 0, 0, 0, f);
    do_instr(C_LOAD,  1, 0, 0, 3, 1, 1, 1, f);
    do_instr(C_ALU,   0, 1, TO - 1, 0, 1, 1, 0, f);

    do_instr(C_ALU, 1, 0, TO, 0, 1, 1, 0, f);
    check_eq("fetch_timeout_flag", 32'(f), 32'd1);
    fault_hold(6);
    do_reset(1);
    do_instr(C_STORE, 0, 0, 0, TO, 1, 1, 0, f);
    check_eq("mem_timeout_flag", 32'(f), 32'd1);
    fault_hold(4);
    do_reset(1);

    for (int n = 0; n < 300; n++) begin
      do_instr($urandom_range(0, 3), rb(), rb(), pick_delay(), pick_delay(),
               2, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0), f);
      if (f) begin
        fault_hold(3);
        do_reset(1);
      end
    end

    // Counter wrap: preload near the top, then retire across 0xFFFF.
    do_reset(0);
    force dut.retired_q = 16'hFFFE;
    #1;
    release dut.retired_q;
    exp_ret = 16'hFFFE;
    cyc(0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, "wrap_go");
    do_instr(C_BR,  0, 1, 0, 0, 1, 1, 0, f);
    do_instr(C_ALU, 1, 0, 0, 0, 1, 1, 0, f);
    do_instr(C_BR,  0, 0, 0, 0, 1, 0, 0, f);
    check_eq("wrap_final", 32'(retired), 32'h0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
